// File: rtl/prbs_pkg.sv
// Shared constants and types for the PRBS-9 transmitter and receiver-side reference generator.
// Polynomial x^9 + x^5 + 1, Fibonacci form; taps are the emitted MSB and bit 4.
package prbs_pkg;
    localparam int PRBS_ORDER = 9;
    localparam int SEQ_LEN    = (1 << PRBS_ORDER) - 1;
    localparam int PHASE_W    = $clog2(SEQ_LEN);
    localparam int TAP_HI     = 8;
    localparam int TAP_LO     = 4;

    localparam logic [PRBS_ORDER-1:0] DEFAULT_SEED = 9'h1FF;

    typedef enum logic {
        INJ_IDLE = 1'b0,
        INJ_RUN  = 1'b1
    } inj_state_e;

    // An all-zero LFSR never leaves zero, so a zero seed falls back to the default.
    function automatic logic [PRBS_ORDER-1:0] safe_seed(
        input logic [PRBS_ORDER-1:0] seed,
        input logic [PRBS_ORDER-1:0] dflt
    );
        return (seed == '0) ? dflt : seed;
    endfunction
endpackage

// File: rtl/prbs_lfsr.sv
// PRBS-9 LFSR core: seed load (priority), one shift per step, emitted bit = state MSB.
// Latency: bit_out is the bit that the next step emits; state advances at the stepping edge.
// Backpressure: none; holds state while step is low.
module prbs_lfsr
    import prbs_pkg::*;
#(
    parameter logic [PRBS_ORDER-1:0] SEED = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  load,
    input  logic [PRBS_ORDER-1:0] seed_in,
    output logic                  bit_out
);
    logic [PRBS_ORDER-1:0] lfsr_q;
    logic [PRBS_ORDER-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = safe_seed(seed_in, SEED);
        end else if (step) begin
            lfsr_d = {lfsr_q[PRBS_ORDER-2:0], lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_out = lfsr_q[PRBS_ORDER-1];
endmodule

// File: rtl/prbs_tx.sv
// PRBS-9 test-pattern transmitter: clean ref_bit, tx_bit with optional periodic error injection.
// Latency: all outputs registered, updated at the edge sampling enable=1; load overrides enable.
// Backpressure: none; enable is a symbol-rate strobe. Injection built only with PRBS_ERR_INJECT_EN.
module prbs_tx
    import prbs_pkg::*;
#(
    parameter logic [PRBS_ORDER-1:0] SEED  = DEFAULT_SEED,
    parameter int                    CNT_W = 32,
    parameter int                    INJ_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [PRBS_ORDER-1:0] seed_in,
    input  logic [INJ_W-1:0]      inj_period,
    output logic                  ref_bit,
    output logic                  tx_bit,
    output logic                  seq_start,
    output logic [CNT_W-1:0]      bit_count,
    output logic [CNT_W-1:0]      inj_count
);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    logic step;
    logic lfsr_bit;
    logic inj_flip;

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               ref_bit_q, ref_bit_d;
    logic               tx_bit_q, tx_bit_d;
    logic               seq_start_q, seq_start_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;
    logic [CNT_W-1:0]   inj_count_q, inj_count_d;

    assign step = enable & ~load;

    prbs_lfsr #(
        .SEED    (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .step    (enable),
        .load    (load),
        .seed_in (seed_in),
        .bit_out (lfsr_bit)
    );

`ifdef PRBS_ERR_INJECT_EN
    localparam logic [INJ_W-1:0] INJ_ONE = INJ_W'(1);

    inj_state_e        state_q, state_d;
    logic [INJ_W-1:0]  inj_cnt_q, inj_cnt_d;

    always_comb begin
        state_d   = state_q;
        inj_cnt_d = inj_cnt_q;
        inj_flip  = 1'b0;
        case (state_q)
            INJ_IDLE: begin
                inj_cnt_d = '0;
                if (inj_period != '0) begin
                    state_d = INJ_RUN;
                end
            end
            INJ_RUN: begin
                if (inj_period == '0) begin
                    state_d   = INJ_IDLE;
                    inj_cnt_d = '0;
                end else if (step) begin
                    // >= rather than == so a lowered period takes effect on the very next bit.
                    if (inj_cnt_q >= inj_period - INJ_ONE) begin
                        inj_flip  = 1'b1;
                        inj_cnt_d = '0;
                    end else begin
                        inj_cnt_d = inj_cnt_q + INJ_ONE;
                    end
                end
            end
            default: begin
                state_d   = INJ_IDLE;
                inj_cnt_d = '0;
            end
        endcase
        if (load) begin
            inj_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= INJ_IDLE;
            inj_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            inj_cnt_q <= inj_cnt_d;
        end
    end
`else
    logic unused_inj_period;

    assign unused_inj_period = ^inj_period;
    assign inj_flip          = 1'b0;
`endif

    always_comb begin
        phase_d     = phase_q;
        ref_bit_d   = ref_bit_q;
        tx_bit_d    = tx_bit_q;
        seq_start_d = seq_start_q;
        bit_count_d = bit_count_q;
        inj_count_d = inj_count_q;
        if (load) begin
            phase_d     = '0;
            ref_bit_d   = 1'b0;
            tx_bit_d    = 1'b0;
            seq_start_d = 1'b0;
            bit_count_d = '0;
            inj_count_d = '0;
        end else if (step) begin
            ref_bit_d   = lfsr_bit;
            tx_bit_d    = lfsr_bit ^ inj_flip;
            seq_start_d = (phase_q == '0);
            phase_d     = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_ONE;
            if (bit_count_q != '1) begin
                bit_count_d = bit_count_q + CNT_ONE;
            end
            if (inj_flip && (inj_count_q != '1)) begin
                inj_count_d = inj_count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= '0;
            ref_bit_q   <= 1'b0;
            tx_bit_q    <= 1'b0;
            seq_start_q <= 1'b0;
            bit_count_q <= '0;
            inj_count_q <= '0;
        end else begin
            phase_q     <= phase_d;
            ref_bit_q   <= ref_bit_d;
            tx_bit_q    <= tx_bit_d;
            seq_start_q <= seq_start_d;
            bit_count_q <= bit_count_d;
            inj_count_q <= inj_count_d;
        end
    end

    assign ref_bit   = ref_bit_q;
    assign tx_bit    = tx_bit_q;
    assign seq_start = seq_start_q;
    assign bit_count = bit_count_q;
    assign inj_count = inj_count_q;
endmodule

// File: tb/tb_prbs_tx.sv
// Bench for prbs_tx: sequence model from the recurrence e[n+9] = e[n] ^ e[n+4], seeded MSB first;
// injected errors expected wherever (n+1) is a multiple of the period in force since the last load.
module tb_prbs_tx;
`ifdef PRBS_ERR_INJECT_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif
    localparam int SEQ_N = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [8:0]  seed_in = '0;
    logic [15:0] inj_period = '0;
    logic        ref_bit, tx_bit, seq_start;
    logic [31:0] bit_count, inj_count;

    int checks = 0;
    int failures = 0;

    bit exp_seq [SEQ_N];
    bit obs_ref [$];
    bit obs_tx  [$];
    bit obs_ss  [$];

    prbs_tx dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .seed_in    (seed_in),
        .inj_period (inj_period),
        .ref_bit    (ref_bit),
        .tx_bit     (tx_bit),
        .seq_start  (seq_start),
        .bit_count  (bit_count),
        .inj_count  (inj_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void gen_seq(input logic [8:0] seed);
        logic [8:0] s;
        s = (seed == 9'd0) ? 9'h1FF : seed;
        for (int i = 0; i < 9; i++) exp_seq[i] = s[8-i];
        for (int n = 0; n + 9 < SEQ_N; n++) exp_seq[n+9] = exp_seq[n] ^ exp_seq[n+4];
    endfunction

    // Emits n bits (continuous when gap_max == 0, else random idle gaps of 1..gap_max cycles).
    task automatic drive_bits(input int n, input int gap_max);
        obs_ref.delete();
        obs_tx.delete();
        obs_ss.delete();
        for (int i = 0; i < n; i++) begin
            enable = 1'b1;
            @(negedge clk);
            obs_ref.push_back(ref_bit);
            obs_tx.push_back(tx_bit);
            obs_ss.push_back(seq_start);
            if (gap_max > 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, gap_max)) @(negedge clk);
            end
        end
        enable = 1'b0;
    endtask

    task automatic do_load(input logic [8:0] seed, input logic en);
        enable  = en;
        load    = 1'b1;
        seed_in = seed;
        @(negedge clk);
        load   = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({ref_bit, tx_bit, seq_start} !== 3'b000 || bit_count !== 32'd0 || inj_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_hold: got ref/tx/ss=%b%b%b bc=%0d ic=%0d want 000 0 0",
                     ref_bit, tx_bit, seq_start, bit_count, inj_count);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({ref_bit, tx_bit, seq_start} !== 3'b000 || bit_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_release: got ref/tx/ss=%b%b%b bc=%0d want 000 0",
                     ref_bit, tx_bit, seq_start, bit_count);
        end
    endtask

    task automatic test_basic;
        gen_seq(9'h1FF);
        drive_bits(20, 0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (obs_ref[i] !== exp_seq[i] || obs_tx[i] !== exp_seq[i] || obs_ss[i] !== (i == 0)) begin
                failures++;
                $display("FAIL basic_bit%0d: got ref=%b tx=%b ss=%b want ref=%b tx=%b ss=%b",
                         i, obs_ref[i], obs_tx[i], obs_ss[i], exp_seq[i], exp_seq[i], i == 0);
            end
        end
        checks++;
        if (bit_count !== 32'd20) begin
            failures++;
            $display("FAIL basic_count: got %0d want 20", bit_count);
        end
    endtask

    task automatic test_period;
        int bad_per;
        inj_period = 16'd0;
        do_load(9'h000, 1'b0);
        gen_seq(9'h1FF);
        drive_bits(1533, 0);
        for (int i = 0; i < 1533; i++) begin
            checks++;
            if (obs_ref[i] !== exp_seq[i] || obs_ss[i] !== (i % 511 == 0)) begin
                failures++;
                $display("FAIL period_bit%0d: got ref=%b ss=%b want ref=%b ss=%b",
                         i, obs_ref[i], obs_ss[i], exp_seq[i], i % 511 == 0);
            end
        end
        bad_per = 0;
        for (int n = 0; n < 1022; n++) if (obs_ref[n] !== obs_ref[n+511]) bad_per++;
        checks++;
        if (bad_per != 0) begin
            failures++;
            $display("FAIL period_repeat: got %0d positions differing from n+511 want 0", bad_per);
        end
        checks++;
        if (bit_count !== 32'd1533) begin
            failures++;
            $display("FAIL period_count: got %0d want 1533", bit_count);
        end
    endtask

    task automatic test_inject;
        int p;
        bit exp_tx;
        inj_period = 16'd100;
        repeat (2) @(negedge clk);
        do_load(9'h000, 1'b0);
        gen_seq(9'h1FF);
        drive_bits(300, 0);
        for (int i = 0; i < 300; i++) begin
            exp_tx = exp_seq[i] ^ (INJ_ON && ((i + 1) % 100 == 0));
            checks++;
            if (obs_ref[i] !== exp_seq[i] || obs_tx[i] !== exp_tx) begin
                failures++;
                $display("FAIL inj100_bit%0d: got ref=%b tx=%b want ref=%b tx=%b",
                         i, obs_ref[i], obs_tx[i], exp_seq[i], exp_tx);
            end
        end
        checks++;
        if (inj_count !== (INJ_ON ? 32'd3 : 32'd0)) begin
            failures++;
            $display("FAIL inj100_count: got %0d want %0d", inj_count, INJ_ON ? 3 : 0);
        end
        for (int t = 0; t < 3; t++) begin
            logic [8:0] sd;
            p  = (t == 0) ? 1 : int'($urandom_range(2, 12));
            sd = 9'($urandom_range(0, 511));
            inj_period = 16'(p);
            repeat (2) @(negedge clk);
            do_load(sd, 1'b0);
            gen_seq(sd);
            drive_bits(40, 3);
            for (int i = 0; i < 40; i++) begin
                exp_tx = exp_seq[i] ^ (INJ_ON && ((i + 1) % p == 0));
                checks++;
                if (obs_ref[i] !== exp_seq[i] || obs_tx[i] !== exp_tx) begin
                    failures++;
                    $display("FAIL inj_rand_p%0d_bit%0d: got ref=%b tx=%b want ref=%b tx=%b",
                             p, i, obs_ref[i], obs_tx[i], exp_seq[i], exp_tx);
                end
            end
            checks++;
            if (inj_count !== (INJ_ON ? 32'(40 / p) : 32'd0)) begin
                failures++;
                $display("FAIL inj_rand_p%0d_count: got %0d want %0d", p, inj_count, INJ_ON ? 40 / p : 0);
            end
            inj_period = 16'd0;
            repeat (2) @(negedge clk);
            drive_bits(10, 0);
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (obs_ref[i] !== exp_seq[40+i] || obs_tx[i] !== exp_seq[40+i]) begin
                    failures++;
                    $display("FAIL inj_off_bit%0d: got ref=%b tx=%b want %b",
                             40 + i, obs_ref[i], obs_tx[i], exp_seq[40+i]);
                end
            end
            checks++;
            if (inj_count !== (INJ_ON ? 32'(40 / p) : 32'd0) || bit_count !== 32'd50) begin
                failures++;
                $display("FAIL inj_off_counts: got ic=%0d bc=%0d want ic=%0d bc=50",
                         inj_count, bit_count, INJ_ON ? 40 / p : 0);
            end
        end
    endtask

    task automatic test_load_zero;
        inj_period = 16'd0;
        do_load(9'h0A5, 1'b0);
        drive_bits(50, 0);
        do_load(9'h000, 1'b1);
        checks++;
        if ({ref_bit, tx_bit, seq_start} !== 3'b000 || bit_count !== 32'd0 || inj_count !== 32'd0) begin
            failures++;
            $display("FAIL load_clear: got ref/tx/ss=%b%b%b bc=%0d ic=%0d want 000 0 0",
                     ref_bit, tx_bit, seq_start, bit_count, inj_count);
        end
        gen_seq(9'h1FF);
        drive_bits(20, 0);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (obs_ref[i] !== exp_seq[i] || obs_tx[i] !== exp_seq[i] || obs_ss[i] !== (i == 0)) begin
                failures++;
                $display("FAIL load0_bit%0d: got ref=%b tx=%b ss=%b want ref=%b ss=%b",
                         i, obs_ref[i], obs_tx[i], obs_ss[i], exp_seq[i], i == 0);
            end
        end
    endtask

    task automatic test_seed_gaps;
        logic [8:0] first9;
        logic [8:0] want9;
        logic       h_ref, h_tx, h_ss;
        logic [31:0] h_bc;
        want9 = 9'b000000001;
        do_load(9'h001, 1'b0);
        gen_seq(9'h001);
        drive_bits(30, 5);
        for (int i = 0; i < 9; i++) first9[8-i] = obs_ref[i];
        checks++;
        if (first9 !== want9) begin
            failures++;
            $display("FAIL seed001_first9: got %b want %b", first9, want9);
        end
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (obs_ref[i] !== exp_seq[i] || obs_ss[i] !== (i == 0)) begin
                failures++;
                $display("FAIL gaps_bit%0d: got ref=%b ss=%b want ref=%b ss=%b",
                         i, obs_ref[i], obs_ss[i], exp_seq[i], i == 0);
            end
        end
        h_ref = ref_bit; h_tx = tx_bit; h_ss = seq_start; h_bc = bit_count;
        repeat (4) @(negedge clk);
        checks++;
        if (ref_bit !== h_ref || tx_bit !== h_tx || seq_start !== h_ss || bit_count !== 32'd30) begin
            failures++;
            $display("FAIL idle_hold: got ref/tx/ss=%b%b%b bc=%0d want %b%b%b bc=30 (before idle %0d)",
                     ref_bit, tx_bit, seq_start, bit_count, h_ref, h_tx, h_ss, h_bc);
        end
    endtask

    task automatic test_reset_mid;
        do_load(9'h000, 1'b0);
        gen_seq(9'h1FF);
        enable = 1'b1;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ref_bit, tx_bit, seq_start} !== 3'b000 || bit_count !== 32'd0 || inj_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_async: got ref/tx/ss=%b%b%b bc=%0d ic=%0d want 000 0 0",
                     ref_bit, tx_bit, seq_start, bit_count, inj_count);
        end
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drive_bits(14, 0);
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (obs_ref[i] !== exp_seq[i] || obs_ss[i] !== (i == 0)) begin
                failures++;
                $display("FAIL reset_mid_bit%0d: got ref=%b ss=%b want ref=%b ss=%b",
                         i, obs_ref[i], obs_ss[i], exp_seq[i], i == 0);
            end
        end
        checks++;
        if (bit_count !== 32'd14) begin
            failures++;
            $display("FAIL reset_mid_count: got %0d want 14", bit_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_period();
        test_inject();
        test_load_zero();
        test_seed_gaps();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
